instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- IF stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from sequential, branch and jump sources.
- Registers the fetched instruction and PC+4 (PCResult) for decode, with hazard stall and branch/jump squash handling.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- DELAY_SLOT, 1, 1 = instruction after a taken branch/jump executes (delay slot); 0 = it is squashed to a bubble.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous active-high reset.
- Stall  input  1  from hazard unit; freezes PC and IF/ID register.
- BranchOut  input  1  taken-branch decision from decode, same cycle.
- BranchAddress  input  32  branch target from decode.
- Jump  input  1  jump/jal/jr decision from decode.
- JumpAddress  input  32  jump target from decode.
- ImemData  input  32  instruction memory read data; combinational w.r.t. ImemAddr.
- ImemAddr  output  32  current PC, to instruction memory.
- Instruction  output  32  IF/ID registered instruction.
- PCResult  output  32  IF/ID registered PC+4 of that instruction.
- Valid  output  1  IF/ID slot holds a real instruction; 0 = bubble.

Behaviour:
- Reset (Rst=1 at edge): PC<=RESET_PC; Instruction<=0 (sll nop); PCResult<=0; Valid<=0. Rst has priority over every other input; a reset mid-stall or mid-redirect discards all pending state.
- ImemAddr = PC, combinational from the PC register, never from next-PC logic.
- PcPlus4 = PC+32'd4, mod 2^32; 32'hFFFFFFFC wraps to 0.
- Next-PC priority, evaluated each edge when Rst=0:
  1. Stall=1: PC, Instruction, PCResult and Valid all hold. BranchOut/Jump are ignored because decode operands are not final.
  2. Jump=1: PC<=JumpAddress. Jump wins over a simultaneous BranchOut.
  3. BranchOut=1: PC<=BranchAddress.
  4. Otherwise: PC<=PcPlus4.
- Targets are forced word aligned: PC[1:0] is always 2'b00; target bits [1:0] are ignored.
- IF/ID load when Stall=0:
  - Default: Instruction<=ImemData; PCResult<=PcPlus4; Valid<=1.
  - Redirect (Jump or BranchOut) with DELAY_SLOT=0: Instruction<=0; PCResult<=PcPlus4; Valid<=0.
  - Redirect with DELAY_SLOT=1: default load; the delay-slot instruction proceeds.
- Latency:
  - Instruction at PC appears on Instruction/PCResult one edge after PC is presented.
  - A redirect seen in decode at cycle n gives ImemAddr=target in cycle n+1.
  - The target instruction reaches decode at n+2.
- Stall lasting k cycles: outputs frozen exactly k edges, then normal flow resumes with no instruction lost or duplicated.
- State machine, 2 states:
  - RUN: normal operation.
  - HOLD: Stall asserted; state register tracks the previous-cycle Stall.
  - RUN->HOLD on Stall=1; HOLD->RUN on Stall=0. Reset enters RUN.
  - The state is used only for the optional counters and debug. The datapath depends only on the current Stall.
- No outputs are combinational from Stall, BranchOut or Jump, except through the PC register.

Optional Feature:
- Macro: IF_PERF_COUNTERS_EN.
- When defined, adds outputs FetchCount[31:0], StallCount[31:0] and SquashCount[31:0]. All reset to 0 and wrap at 2^32.
  - FetchCount increments on each edge with Stall=0 that loads Valid=1.
  - StallCount increments on each edge with Stall=1.
  - SquashCount increments on each edge that loads a bubble due to a redirect (DELAY_SLOT=0 only; stays 0 otherwise).
- StallEpisodes[15:0] counts RUN->HOLD transitions.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then free-run, memory returns word index: ImemAddr 0,4,8,12. One cycle after each address: Instruction = that word, PCResult = addr+4, Valid = 1 from the first post-reset edge.
- Stall=1 for 3 cycles at PC=8: ImemAddr stays 8; Instruction/PCResult hold the PC=4 entry for 3 edges; next edge loads the PC=8 word. No skip, no duplicate.
- DELAY_SLOT=1, BranchOut=1, BranchAddress=0x40 while PC=0x10: next ImemAddr=0x40; the 0x10 instruction enters IF/ID with Valid=1. DELAY_SLOT=0, same stimulus: Instruction=0, Valid=0, PCResult=0x14.
- Jump=1 (JumpAddress=0x100) and BranchOut=1 (BranchAddress=0x200) together: PC=0x100. Also Stall=1 with Jump=1: PC holds and the jump is ignored.
- RESET_PC=0xFFFFFFF8, free-run: ImemAddr 0xFFFFFFF8, 0xFFFFFFFC, 0x0. PCResult for 0xFFFFFFFC equals 0. JumpAddress=0x103 loads PC=0x100.
- Rst=1 during a stall with a redirect pending: next edge PC=RESET_PC, Valid=0, Instruction=0. With IF_PERF_COUNTERS_EN defined, all counters read 0.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Holds the PC, drives instruction memory, selects the next PC from the
// sequential/branch/jump sources and registers the fetched word and its
// PC+4 for decode, with stall and redirect handling.
// Optional performance counters are enabled by defining IF_PERF_COUNTERS_EN.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned DELAY_SLOT = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        BranchOut,
    input  logic [31:0] BranchAddress,
    input  logic        Jump,
    input  logic [31:0] JumpAddress,
    input  logic [31:0] ImemData,
    output logic [31:0] ImemAddr,
    output logic [31:0] Instruction,
    output logic [31:0] PCResult,
    output logic        Valid
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
    output logic [31:0] SquashCount,
    output logic [15:0] StallEpisodes
`endif
);

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};
    localparam bit          SquashSlot     = (DELAY_SLOT == 0);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcResult_q, pcResult_d;
    logic        valid_q, valid_d;

    logic [31:0] pcPlus4;
    logic        redirect;
    logic        squash;
    logic        unusedTargetBits;

    // Targets are word aligned, so the low two target bits carry no meaning.
    assign unusedTargetBits = ^{BranchAddress[1:0], JumpAddress[1:0]};

    assign pcPlus4  = pc_q + 32'd4;
    assign redirect = Jump | BranchOut;
    assign squash   = redirect && SquashSlot;

    // Next PC and IF/ID contents; a stall freezes everything and ignores redirects.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pcResult_d = pcResult_q;
        valid_d    = valid_q;
        if (!Stall) begin
            if (Jump) begin
                pc_d = {JumpAddress[31:2], 2'b00};
            end else if (BranchOut) begin
                pc_d = {BranchAddress[31:2], 2'b00};
            end else begin
                pc_d = pcPlus4;
            end
            pcResult_d = pcPlus4;
            if (squash) begin
                instr_d = 32'h0000_0000;
                valid_d = 1'b0;
            end else begin
                instr_d = ImemData;
                valid_d = 1'b1;
            end
        end
    end

    // PC and IF/ID register; reset wins over stall and pending redirects.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q       <= ResetPcAligned;
            instr_q    <= 32'h0000_0000;
            pcResult_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pcResult_q <= pcResult_d;
            valid_q    <= valid_d;
        end
    end

    assign ImemAddr    = pc_q;
    assign Instruction = instr_q;
    assign PCResult    = pcResult_q;
    assign Valid       = valid_q;

`ifdef IF_PERF_COUNTERS_EN
    // The RUN/HOLD state mirrors the previous-cycle stall; it only feeds the counters.
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetchState_e;

    fetchState_e state_q, state_d;

    logic [31:0] fetchCount_q, stallCount_q, squashCount_q;
    logic [15:0] stallEpisodes_q;

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic tracking the stall input.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (Stall)  state_d = HOLD;
            HOLD:    if (!Stall) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Event counters, all free-running and wrapping.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            fetchCount_q    <= 32'd0;
            stallCount_q    <= 32'd0;
            squashCount_q   <= 32'd0;
            stallEpisodes_q <= 16'd0;
        end else begin
            if (!Stall && valid_d) fetchCount_q <= fetchCount_q + 32'd1;
            if (Stall) stallCount_q <= stallCount_q + 32'd1;
            if (!Stall && squash) squashCount_q <= squashCount_q + 32'd1;
            if (state_q == RUN && state_d == HOLD) stallEpisodes_q <= stallEpisodes_q + 16'd1;
        end
    end

    assign FetchCount    = fetchCount_q;
    assign StallCount    = stallCount_q;
    assign SquashCount   = squashCount_q;
    assign StallEpisodes = stallEpisodes_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage.
// Three instances share stimulus: default (delay slot, PC from 0),
// squashing variant (DELAY_SLOT=0) and a wrap variant (RESET_PC=0xFFFFFFF8).
module tb_instruction_fetch_stage;

    localparam int N = 3;
    localparam logic [31:0] RP0 = 32'h0000_0000;
    localparam logic [31:0] RP2 = 32'hFFFF_FFF8;

    logic        Clk;
    logic        Rst, Stall, BranchOut, Jump;
    logic [31:0] BranchAddress, JumpAddress;

    logic [31:0] imemAddr [N];
    logic [31:0] imemData [N];
    logic [31:0] instr    [N];
    logic [31:0] pcRes    [N];
    logic        valid    [N];
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetchCnt  [N];
    logic [31:0] stallCnt  [N];
    logic [31:0] squashCnt [N];
    logic [15:0] episodes  [N];
`endif

    // Reference model state
    logic [31:0] mPc [N], mInstr [N], mPcRes [N];
    logic        mValid [N];
    logic [31:0] mFetch [N], mStall [N], mSquash [N];
    logic [15:0] mEpis [N];
    logic        mPrevStall;
    logic [31:0] resetPc [N];
    bit          delaySlot [N];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a >> 2) ^ 32'hC0DE_0000;
    endfunction

    assign imemData[0] = memWord(imemAddr[0]);
    assign imemData[1] = memWord(imemAddr[1]);
    assign imemData[2] = memWord(imemAddr[2]);

    instruction_fetch_stage #(.RESET_PC(RP0), .DELAY_SLOT(1)) dut0 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .BranchOut(BranchOut),
        .BranchAddress(BranchAddress), .Jump(Jump), .JumpAddress(JumpAddress),
        .ImemData(imemData[0]), .ImemAddr(imemAddr[0]), .Instruction(instr[0]),
        .PCResult(pcRes[0]), .Valid(valid[0])
`ifdef IF_PERF_COUNTERS_EN
        , .FetchCount(fetchCnt[0]), .StallCount(stallCnt[0]),
        .SquashCount(squashCnt[0]), .StallEpisodes(episodes[0])
`endif
    );

    instruction_fetch_stage #(.RESET_PC(RP0), .DELAY_SLOT(0)) dut1 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .BranchOut(BranchOut),
        .BranchAddress(BranchAddress), .Jump(Jump), .JumpAddress(JumpAddress),
        .ImemData(imemData[1]), .ImemAddr(imemAddr[1]), .Instruction(instr[1]),
        .PCResult(pcRes[1]), .Valid(valid[1])
`ifdef IF_PERF_COUNTERS_EN
        , .FetchCount(fetchCnt[1]), .StallCount(stallCnt[1]),
        .SquashCount(squashCnt[1]), .StallEpisodes(episodes[1])
`endif
    );

    instruction_fetch_stage #(.RESET_PC(RP2), .DELAY_SLOT(1)) dut2 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .BranchOut(BranchOut),
        .BranchAddress(BranchAddress), .Jump(Jump), .JumpAddress(JumpAddress),
        .ImemData(imemData[2]), .ImemAddr(imemAddr[2]), .Instruction(instr[2]),
        .PCResult(pcRes[2]), .Valid(valid[2])
`ifdef IF_PERF_COUNTERS_EN
        , .FetchCount(fetchCnt[2]), .StallCount(stallCnt[2]),
        .SquashCount(squashCnt[2]), .StallEpisodes(episodes[2])
`endif
    );

    // Free-running clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one clock edge using the rules of the stage.
    task automatic modelEdge(input logic rst, input logic stall, input logic br,
                             input logic [31:0] ba, input logic j, input logic [31:0] ja);
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                mPc[k] = resetPc[k]; mInstr[k] = 0; mPcRes[k] = 0; mValid[k] = 0;
                mFetch[k] = 0; mStall[k] = 0; mSquash[k] = 0; mEpis[k] = 0;
            end else if (stall) begin
                mStall[k] = mStall[k] + 1;
                if (!mPrevStall) mEpis[k] = mEpis[k] + 1;
            end else begin
                logic [31:0] nextSeq;
                logic [31:0] target;
                nextSeq = mPc[k] + 4;
                target  = j ? ja : ba;
                target  = target & 32'hFFFF_FFFC;
                mPcRes[k] = nextSeq;
                if ((j || br) && !delaySlot[k]) begin
                    mInstr[k] = 0; mValid[k] = 0; mSquash[k] = mSquash[k] + 1;
                end else begin
                    mInstr[k] = memWord(mPc[k]); mValid[k] = 1; mFetch[k] = mFetch[k] + 1;
                end
                mPc[k] = (j || br) ? target : nextSeq;
            end
        end
        mPrevStall = rst ? 1'b0 : stall;
    endtask

    // Drive one cycle of inputs, clock it, then compare every instance with the model.
    task automatic applyStimulus(input logic rst, input logic stall, input logic br,
                                 input logic [31:0] ba, input logic j, input logic [31:0] ja);
        @(negedge Clk);
        Rst = rst; Stall = stall; BranchOut = br; BranchAddress = ba;
        Jump = j; JumpAddress = ja;
        @(posedge Clk);
        #1;
        modelEdge(rst, stall, br, ba, j, ja);
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("i%0d.addr", k), imemAddr[k], mPc[k]);
            checkOutput($sformatf("i%0d.instr", k), instr[k], mInstr[k]);
            checkOutput($sformatf("i%0d.pcres", k), pcRes[k], mPcRes[k]);
            checkOutput($sformatf("i%0d.valid", k), {31'd0, valid[k]}, {31'd0, mValid[k]});
`ifdef IF_PERF_COUNTERS_EN
            checkOutput($sformatf("i%0d.fetch", k), fetchCnt[k], mFetch[k]);
            checkOutput($sformatf("i%0d.stallc", k), stallCnt[k], mStall[k]);
            checkOutput($sformatf("i%0d.squash", k), squashCnt[k], mSquash[k]);
            checkOutput($sformatf("i%0d.epis", k), {16'd0, episodes[k]}, {16'd0, mEpis[k]});
`endif
        end
    endtask

    initial begin
        resetPc[0] = RP0; resetPc[1] = RP0; resetPc[2] = RP2;
        delaySlot[0] = 1; delaySlot[1] = 0; delaySlot[2] = 1;
        for (int k = 0; k < N; k++) begin
            mPc[k] = 0; mInstr[k] = 0; mPcRes[k] = 0; mValid[k] = 0;
            mFetch[k] = 0; mStall[k] = 0; mSquash[k] = 0; mEpis[k] = 0;
        end
        mPrevStall = 0;
        Rst = 1; Stall = 0; BranchOut = 0; Jump = 0; BranchAddress = 0; JumpAddress = 0;

        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rst.addr0", imemAddr[0], 32'h0);
        checkOutput("rst.addr2", imemAddr[2], 32'hFFFF_FFF8);
        checkOutput("rst.valid", {31'd0, valid[0]}, 32'd0);

        // Free run: first word lands one edge after its address
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("run.instr0", instr[0], 32'hC0DE_0000);
        checkOutput("run.pcres0", pcRes[0], 32'd4);
        checkOutput("run.valid0", {31'd0, valid[0]}, 32'd1);
        checkOutput("run.addr2", imemAddr[2], 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrap.addr2", imemAddr[2], 32'h0);
        checkOutput("wrap.pcres2", pcRes[2], 32'h0);

        // Three-cycle stall at PC=8 with a redirect that must be ignored
        for (int s = 0; s < 3; s++) begin
            applyStimulus(0, 1, 1, 32'h500, 0, 0);
            checkOutput("stall.addr", imemAddr[0], 32'd8);
            checkOutput("stall.pcres", pcRes[0], 32'd8);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("resume.instr", instr[0], memWord(32'd8));
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Taken branch at PC=0x10
        applyStimulus(0, 0, 1, 32'h40, 0, 0);
        checkOutput("br.addr", imemAddr[0], 32'h40);
        checkOutput("br.ds.instr", instr[0], memWord(32'h10));
        checkOutput("br.sq.instr", instr[1], 32'h0);
        checkOutput("br.sq.valid", {31'd0, valid[1]}, 32'd0);
        checkOutput("br.sq.pcres", pcRes[1], 32'h14);

        // Jump beats branch; stall suppresses jump; target alignment
        applyStimulus(0, 0, 1, 32'h200, 1, 32'h100);
        checkOutput("jb.addr", imemAddr[0], 32'h100);
        applyStimulus(0, 1, 0, 0, 1, 32'h300);
        checkOutput("sj.addr", imemAddr[0], 32'h100);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h103);
        checkOutput("align.addr", imemAddr[0], 32'h100);

        // Reset during a stall with a redirect pending
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 32'h80, 1, 32'h90);
        checkOutput("rstmid.addr", imemAddr[0], 32'h0);
        checkOutput("rstmid.valid", {31'd0, valid[0]}, 32'd0);
        checkOutput("rstmid.instr", instr[0], 32'h0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) == 0), $urandom,
                          ($urandom_range(0, 5) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
